nibble_serial_subtractor: RTL and testbench

Sequential controller that performs a wide unsigned subtraction A − B one nibble per cycle on a single external 4-bit ripple-carry subtractor (four_bit_RCS). It sits on both sides of that subtractor: it drives the 4-bit operand slices and carry-in, then captures the difference and carry-out, chaining the carry between nibbles. Operands arrive and results leave through valid/ready handshakes.

---
 rtl/nibble_serial_subtractor.sv | 137 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_serial_subtractor                                     |
// | Description : Wide unsigned subtractor A - B that works one nibble per     |
// |               clock through an external 4-bit ripple-carry subtractor.     |
// |               It drives the operand slices and carry-in, captures the      |
// |               difference nibble and carry-out, and chains the carry from   |
// |               one nibble to the next.                                      |
// | Ports       : clk, rst_n           - clock, async active-low reset         |
// |               in_valid/in_ready    - operand handshake (in_a, in_b)        |
// |               rcs_a/rcs_b/rcs_cin  - operand slices and carry to the RCS   |
// |               rcs_s/rcs_cout       - difference nibble and carry from RCS  |
// |               out_valid/out_ready  - result handshake                      |
// |               out_diff/out_borrow/out_zero - result and flags              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_serial_subtractor #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_a,
   input  logic [4*NIBBLES-1:0]   in_b,
   output logic [3:0]             rcs_a,
   output logic [3:0]             rcs_b,
   output logic                   rcs_cin,
   input  logic [3:0]             rcs_s,
   input  logic                   rcs_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_diff,
   output logic                   out_borrow,
   output logic                   out_zero
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     diff_q, diff_d;

   // Bit offset of the nibble currently being processed.
   logic [IDX_W+1:0] w_bit_base;
   assign w_bit_base = {idx_q, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      rcs_a      = 4'h0;
      rcs_b      = 4'h0;
      rcs_cin    = 1'b1;
      out_borrow = 1'b0;
      out_zero   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               idx_d   = '0;
               // Carry of 1 means "no borrow" into the least significant nibble.
               carry_d = 1'b1;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            rcs_a   = a_q[w_bit_base +: 4];
            rcs_b   = b_q[w_bit_base +: 4];
            rcs_cin = carry_q;
            diff_d[w_bit_base +: 4] = rcs_s;
            carry_d = rcs_cout;
            if (idx_q == C_LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         ST_DONE: begin
            out_valid  = 1'b1;
            // Final carry of 0 means the whole subtraction borrowed (A < B).
            out_borrow = ~carry_q;
            out_zero   = (diff_q == '0);
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_diff = diff_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nibble_serial_subtractor                                  |
// | Description : Self-checking bench for nibble_serial_subtractor. Models the |
// |               external 4-bit subtractor, applies directed vectors, corner  |
// |               sequences and random operations against a plain-arithmetic   |
// |               reference.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nibble_serial_subtractor;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b;
   logic [3:0]   rcs_a, rcs_b, rcs_s;
   logic         rcs_cin, rcs_cout;
   logic         out_valid, out_ready;
   logic [W-1:0] out_diff;
   logic         out_borrow, out_zero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // External four_bit_RCS: A + ~B + Cin.
   assign {rcs_cout, rcs_s} = {1'b0, rcs_a} + {1'b0, ~rcs_b} + {4'b0000, rcs_cin};

   nibble_serial_subtractor #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .rcs_a     (rcs_a),
      .rcs_b     (rcs_b),
      .rcs_cin   (rcs_cin),
      .rcs_s     (rcs_s),
      .rcs_cout  (rcs_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_borrow(out_borrow),
      .out_zero  (out_zero)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         borrow;
      logic         zero;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: carry into nibble i is 1 exactly when the low 4*i bits of A
   // are not smaller than those of B (no borrow out of the lower part).
   function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
      logic [W:0]   one;
      logic [W-1:0] m;
      if (i == 0) return 1'b1;
      one = 1;
      m   = W'((one << (4 * i)) - 1);
      return (a & m) >= (b & m);
   endfunction

   // Wait for in_ready (bounded), present operands, let the next edge accept.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("in_ready_timeout", 0, 1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Follows an accepted operation: checks latency, nibble slices, carry chain,
   // result, and optionally releases the result after 'delay' stall cycles.
   task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_diff, input logic e_borrow,
                          input logic e_zero, input int delay,
                          input bit release_now, input string name);
      int  lat = -1;
      bit  cin_ok = 1, slice_ok = 1, stable_ok = 1;
      for (int c = 1; c <= NIB + 8; c++) begin
         @(negedge clk);
         if (c == 1) check({name, "_in_ready_run"}, in_ready, 0);
         if (out_valid) begin
            lat = c - 1;
            break;
         end
         if (c - 1 < NIB) begin
            if (rcs_cin !== ref_cin(a, b, c - 1)) cin_ok = 0;
            if (rcs_a !== a[4*(c-1) +: 4] || rcs_b !== b[4*(c-1) +: 4]) slice_ok = 0;
         end
      end
      if (lat < 0) begin
         check({name, "_out_valid_timeout"}, 0, 1);
         return;
      end
      check({name, "_latency"}, lat, NIB);
      check({name, "_cin_seq"}, cin_ok, 1);
      check({name, "_slices"}, slice_ok, 1);
      check({name, "_diff"}, out_diff, e_diff);
      check({name, "_borrow"}, out_borrow, e_borrow);
      check({name, "_zero"}, out_zero, e_zero);
      if (!release_now) return;
      if (out_ready) begin
         @(negedge clk);
      end else begin
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!out_valid || out_diff !== e_diff) stable_ok = 0;
         end
         check({name, "_stall_stable"}, stable_ok, 1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      check({name, "_released"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      logic [W-1:0] ra, rb, held;
      int           dly;

      vecs[0] = '{16'h0005, 16'h0001, 16'h0004, 1'b0, 1'b0};
      vecs[1] = '{16'h0005, 16'h0008, 16'hFFFD, 1'b1, 1'b0};
      vecs[2] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
      vecs[3] = '{16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
      vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_diff", out_diff, 0);
      check("rst_flags", {out_borrow, out_zero}, 2'b00);
      check("rst_rcs", {rcs_a, rcs_b, rcs_cin}, 9'b0000_0000_1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with out_ready already high (one-cycle DONE).
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].a, vecs[i].b);
         collect(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].zero,
                 0, 1, $sformatf("vec%0d", i));
      end

      // Backpressure with new operands pending on the input side.
      out_ready = 1'b0;
      issue(16'h1234, 16'h0234);
      collect(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 0, 0, "bp");
      held     = out_diff;
      in_a     = 16'h0050;
      in_b     = 16'h0007;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_diff}, {2'b10, held});
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_gap", {out_valid, in_ready}, 2'b01);
      @(posedge clk);
      #1 in_valid = 1'b0;
      collect(16'h0050, 16'h0007, 16'h0049, 1'b0, 1'b0, 0, 1, "bp_next");

      // Reset while in RUN at idx=2.
      issue(16'h7777, 16'h1111);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_run_outs", {out_valid, in_ready, rcs_cin}, 3'b011);
      check("rst_run_rcs", {rcs_a, rcs_b}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h0003, 16'h0001);
      collect(16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1, "after_rst");

      // Reset while in DONE: out_valid must drop without waiting for an edge.
      out_ready = 1'b0;
      issue(16'h0100, 16'h0200);
      collect(16'h0100, 16'h0200, 16'hFF00, 1'b1, 1'b0, 0, 0, "done_rst");
      #1 rst_n = 1'b0;
      #1;
      check("rst_done_outs", {out_valid, in_ready, out_borrow, out_zero}, 4'b0100);
      check("rst_done_diff", out_diff, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random operations against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
         dly = $urandom_range(0, 3);
         out_ready = (dly == 0);
         issue(ra, rb);
         collect(ra, rb, ra - rb, ra < rb, (ra - rb) == 0, dly, 1, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
